pattern_stimulus_gen: RTL

Clocked, parametrised stimulus source for combinational gate benches. It generalises the free-running binary toggle pattern into a synchronous generator with selectable sequence modes, a per-vector dwell time and a valid/ready handshake to the consumer (DUT driver/checker). It runs one complete sequence per start request, then flags completion.

---
 rtl/pattern_stimulus_gen.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pattern_stimulus_gen.sv
// Clocked stimulus source for combinational gate benches: steps through a binary,
// Gray, walking-one or LFSR sequence and hands each vector over with valid/ready.
module pattern_stimulus_gen #(
   parameter int               WIDTH     = 4,
   parameter int               DWELL     = 1,
   parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(4'b1100)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] vec_out,
   output logic             vec_valid,
   input  logic             vec_ready,
   output logic [WIDTH-1:0] vec_index,
   output logic             busy,
   output logic             done
);

   localparam int               CNT_W      = $clog2(DWELL) + 1;
   localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
   localparam logic [WIDTH-1:0] LAST_COUNT = '1;
   localparam logic [WIDTH-1:0] LAST_WALK  = WIDTH'(WIDTH - 1);
   localparam logic [WIDTH-1:0] LAST_LFSR  = LAST_COUNT - ONE;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       mode_q, mode_d;
   logic [WIDTH-1:0] vec_q, vec_d;
   logic [WIDTH-1:0] index_q, index_d;
   logic [CNT_W-1:0] dwell_q, dwell_d;
   logic [WIDTH-1:0] index_inc;
   logic [WIDTH-1:0] next_vec;
   logic [WIDTH-1:0] last_index;
   logic             transfer;

   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
      return {v[WIDTH-2:0], ^(v & LFSR_TAPS)};
   endfunction

   // Walking-one and LFSR both start from bit0 set; the LFSR must never see zero.
   function automatic logic [WIDTH-1:0] first_vector(input logic [1:0] m);
      return (m[1]) ? ONE : '0;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         mode_q  <= 2'd0;
         vec_q   <= '0;
         index_q <= '0;
         dwell_q <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         vec_q   <= vec_d;
         index_q <= index_d;
         dwell_q <= dwell_d;
      end
   end

   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);
   assign vec_valid = busy && (dwell_q == '0);
   assign transfer  = vec_valid && vec_ready;
   assign vec_out   = vec_q;
   assign vec_index = index_q;

   // Successor vector and final index depend only on the mode latched at start.
   always_comb begin
      index_inc  = index_q + ONE;
      next_vec   = '0;
      last_index = LAST_COUNT;
      case (mode_q)
         2'd0: begin
            next_vec   = index_inc;
            last_index = LAST_COUNT;
         end
         2'd1: begin
            next_vec   = index_inc ^ (index_inc >> 1);
            last_index = LAST_COUNT;
         end
         2'd2: begin
            next_vec   = vec_q << 1;
            last_index = LAST_WALK;
         end
         default: begin
            next_vec   = lfsr_step(vec_q);
            last_index = LAST_LFSR;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      vec_d   = vec_q;
      index_d = index_q;
      dwell_d = dwell_q;
      case (state_q)
         IDLE: begin
            vec_d   = '0;
            index_d = '0;
            dwell_d = '0;
            if (start) begin
               mode_d  = mode;
               vec_d   = first_vector(mode);
               dwell_d = DWELL_LOAD;
               state_d = RUN;
            end
         end
         RUN: begin
            // An abort wins over a coinciding transfer; the consumer already has its vector.
            if (stop) begin
               vec_d   = '0;
               index_d = '0;
               dwell_d = '0;
               state_d = IDLE;
            end else if (transfer) begin
               if (index_q == last_index) begin
                  state_d = DONE;
               end else begin
                  index_d = index_inc;
                  vec_d   = next_vec;
                  dwell_d = DWELL_LOAD;
               end
            end else if (dwell_q != '0) begin
               dwell_d = dwell_q - CNT_ONE;
            end
         end
         DONE: begin
            vec_d   = '0;
            index_d = '0;
            dwell_d = '0;
            state_d = IDLE;
         end
         default: begin
            vec_d   = '0;
            index_d = '0;
            dwell_d = '0;
            state_d = IDLE;
         end
      endcase
   end

endmodule
